// File: rtl/vga_capture.sv
// vga_capture: sink end of the VGA pixel interface.
// Registers the incoming sync/valid/RGB stream, rebuilds pixel coordinates and
// writes every visible pixel to a frame-buffer port addressed {h[9:0], v[8:0]}.
// Reports frame completion, a captured-frame count and sticky timing errors.
// Optional feature macro: VGA_CAPTURE_CHECKSUM_EN adds a per-frame 32-bit pixel
// checksum output; without it the checksum logic and port are absent.
module vga_capture #(
  parameter int   H_ACTIVE = 640,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        err_clr,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        line_err,
  output logic        frame_err,
  output logic        busy
`ifdef VGA_CAPTURE_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int DATA_W = 24;

  // Capture FSM. S_SKIP is the "frame declined" half of waiting: a frame whose
  // first pixel arrived with cap_en low is ignored until the next vsync.
  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_SKIP   = 2'd3;

  localparam logic [10:0] H_MAX = 11'(H_ACTIVE);
  localparam logic [9:0]  V_MAX = 10'(V_ACTIVE);
  // One past the last visible line, so a surplus line is still distinguishable.
  localparam logic [9:0]  V_SAT = 10'(V_ACTIVE + 1);

  // Horizontal position saturates at H_ACTIVE so over-long lines cannot wrap.
  function automatic logic [10:0] h_sat_inc(input logic [10:0] x);
    return (x >= H_MAX) ? x : x + 11'd1;
  endfunction

  // Vertical position saturates one line beyond the visible area.
  function automatic logic [9:0] v_sat_inc(input logic [9:0] x);
    return (x >= V_SAT) ? x : x + 10'd1;
  endfunction

  // ---- stage p0: input register ----
  logic              hs_p0, vs_p0, vld_p0, cap_p0, clr_p0;
  logic [DATA_W-1:0] rgb_p0;
  // ---- stage p1: previous p0 values, used for edge detection ----
  logic              hs_p1, vs_p1, vld_p1;

  logic [1:0]  state;
  logic [10:0] h;
  logic [9:0]  v;

  logic [1:0]  state_nx;
  logic [10:0] h_nx;
  logic [9:0]  v_nx;
  logic        wr_nx;
  logic [18:0] addr_nx;
  logic        done_nx;
  logic        start_nx;
  logic        line_set;
  logic        frame_set;

  logic        hs_edge, vs_edge, vld_fall;

  // Register control inputs; syncs reset to their asserted level so that reset
  // release alone never looks like an assertion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_p0  <= SYNC_POL;
      vs_p0  <= SYNC_POL;
      vld_p0 <= 1'b0;
      cap_p0 <= 1'b0;
      clr_p0 <= 1'b0;
      hs_p1  <= SYNC_POL;
      vs_p1  <= SYNC_POL;
      vld_p1 <= 1'b0;
    end else begin
      hs_p0  <= vga_hsync;
      vs_p0  <= vga_vsync;
      vld_p0 <= vga_valid;
      cap_p0 <= cap_en;
      clr_p0 <= err_clr;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vld_p1 <= vld_p0;
    end
  end

  // Register the pixel colour alongside vld_p0.
  always_ff @(posedge clk) begin
    rgb_p0 <= {vga_r, vga_g, vga_b};
  end

  assign hs_edge  = (hs_p0 == SYNC_POL) && (hs_p1 != SYNC_POL);
  assign vs_edge  = (vs_p0 == SYNC_POL) && (vs_p1 != SYNC_POL);
  assign vld_fall = vld_p1 && !vld_p0;

  // Next-state, coordinate tracking and write/error decisions for the p0 pixel.
  always_comb begin
    state_nx  = state;
    h_nx      = h;
    v_nx      = v;
    wr_nx     = 1'b0;
    addr_nx   = {h[9:0], v[8:0]};
    done_nx   = 1'b0;
    start_nx  = 1'b0;
    line_set  = 1'b0;
    frame_set = 1'b0;
    case (state)
      S_HUNT: begin
        if (vs_edge) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (vld_p0) begin
          if (cap_p0) begin
            state_nx = S_ACTIVE;
            start_nx = 1'b1;
            wr_nx    = 1'b1;
            addr_nx  = 19'd0;
            h_nx     = 11'd1;
            v_nx     = 10'd0;
          end else begin
            state_nx = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (vs_edge) state_nx = S_WAIT;
      end
      S_ACTIVE: begin
        if (vs_edge) begin
          frame_set = (v != V_MAX);
          done_nx   = 1'b1;
          state_nx  = S_WAIT;
        end else if (vld_p0 && hs_edge) begin
          // Line sync during active video: flag it and start a new line.
          line_set = 1'b1;
          h_nx     = 11'd0;
          v_nx     = v_sat_inc(v);
        end else if (vld_p0) begin
          wr_nx     = (h < H_MAX) && (v < V_MAX);
          line_set  = (h >= H_MAX);
          frame_set = (v >= V_MAX);
          h_nx      = h_sat_inc(h);
        end else if (vld_fall) begin
          line_set = (h != H_MAX);
          h_nx     = 11'd0;
          v_nx     = v_sat_inc(v);
        end
      end
      default: state_nx = S_HUNT;
    endcase
  end

  // ---- output stage: write port, frame status and sticky errors ----
  // Control state and outputs; a new error in the err_clr cycle keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HUNT;
      h          <= 11'd0;
      v          <= 10'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 19'd0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      h          <= h_nx;
      v          <= v_nx;
      wr_en      <= wr_nx;
      frame_done <= done_nx;
      if (wr_nx) begin
        wr_addr <= addr_nx;
        wr_data <= rgb_p0;
      end
      if (done_nx) frame_cnt <= frame_cnt + 16'd1;
      line_err  <= line_set  | (line_err  & ~clr_p0);
      frame_err <= frame_set | (frame_err & ~clr_p0);
    end
  end

  assign busy = (state == S_ACTIVE);

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] acc;

  // Running sum of written pixels, restarted by the first pixel of a frame.
  always_ff @(posedge clk) begin
    if (start_nx)   acc <= {8'h00, rgb_p0};
    else if (wr_nx) acc <= acc + {8'h00, rgb_p0};
  end

  // Publish the frame's sum together with frame_done and hold it until the next.
  always_ff @(posedge clk) begin
    if (rst)          checksum <= 32'd0;
    else if (done_nx) checksum <= acc;
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frames on a reduced 8x6 raster; a scoreboard of
// expected writes/frame_done pulses is built from the pixels the bench drives.
module tb_vga_capture;

  localparam int   HA  = 8;
  localparam int   VA  = 6;
  localparam int   HFP = 1;
  localparam int   HSW = 2;
  localparam int   HBP = 1;
  localparam int   HT  = HA + HFP + HSW + HBP;
  localparam int   VFP = 1;
  localparam int   VSW = 2;
  localparam int   VBP = 1;
  localparam logic SP  = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_en = 1'b1;
  logic        err_clr = 1'b0;
  logic        vga_hsync = ~SP;
  logic        vga_vsync = ~SP;
  logic        vga_valid = 1'b0;
  logic [7:0]  vga_r = 8'd0;
  logic [7:0]  vga_g = 8'd0;
  logic [7:0]  vga_b = 8'd0;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        line_err;
  logic        frame_err;
  logic        busy;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(SP)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .err_clr(err_clr),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_valid(vga_valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .line_err(line_err), .frame_err(frame_err), .busy(busy)
`ifdef VGA_CAPTURE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  typedef struct packed {
    int          cyc;
    logic [18:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t         wq[$];
  int          fq[$];
  int          cyc = 0;
  int          n_tot = 0;
  int          n_pass = 0;
  int          mcnt = 0;
  bit          mline = 1'b0;
  bit          mfer = 1'b0;
  int          nwr = 0;
  logic [18:0] last_addr = '0;
  logic [23:0] last_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle comparison against the scoreboard.
  initial begin
    wr_t e;
    bit  exp_wr;
    bit  exp_fd;
    forever begin
      @(posedge clk);
      #1;
      exp_wr = (wq.size() > 0) && (wq[0].cyc == cyc);
      check("wr_en", {63'd0, wr_en}, {63'd0, exp_wr});
      if (exp_wr) begin
        e = wq.pop_front();
        if (wr_en) begin
          check("wr_pixel", {21'd0, wr_addr, wr_data}, {21'd0, e.addr, e.data});
          nwr++;
          last_addr = wr_addr;
          last_data = wr_data;
        end
      end
      exp_fd = (fq.size() > 0) && (fq[0] == cyc);
      check("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
      if (exp_fd) begin
        void'(fq.pop_front());
        mcnt = (mcnt + 1) & 16'hFFFF;
        check("frame_cnt", {48'd0, frame_cnt}, 64'(mcnt));
        check("line_err_at_done", {63'd0, line_err}, {63'd0, mline});
        check("frame_err_at_done", {63'd0, frame_err}, {63'd0, mfer});
      end
    end
  end

  // Blank cycles between frames, optionally with an err_clr pulse.
  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vga_valid = 1'b0;
      vga_hsync = ~SP;
      vga_vsync = ~SP;
      err_clr   = clr && (i == 0);
    end
    if (clr) begin
      mline = 1'b0;
      mfer  = 1'b0;
      check("line_err_cleared", {63'd0, line_err}, 64'd0);
      check("frame_err_cleared", {63'd0, frame_err}, 64'd0);
    end
  endtask

  // One frame: nvis visible lines, then front porch, vsync, back porch lines.
  task automatic drive_frame(input int nvis, input int short_line, input bit cap,
                             input int rst_line, input int rst_px,
                             input int cap_line, input bit ones);
    int          nlines;
    bit          capturing;
    bit          vs_a;
    int          len;
    logic [23:0] d;
    nlines    = nvis + VFP + VSW + VBP;
    capturing = cap;
    for (int ln = 0; ln < nlines; ln++) begin
      vs_a = (ln >= nvis + VFP) && (ln < nvis + VFP + VSW);
      len  = (ln < nvis) ? ((ln == short_line) ? HA - 1 : HA) : 0;
      if (capturing && ln == short_line) mline = 1'b1;
      if (capturing && ln >= VA && ln < nvis) mfer = 1'b1;
      for (int px = 0; px < HT; px++) begin
        @(negedge clk);
        if (ln == cap_line && px == 0) cap_en = 1'b1;
        rst = (ln == rst_line) && (px == rst_px);
        if (rst) begin
          while (wq.size() > 0 && wq[$].cyc >= cyc + 1) void'(wq.pop_back());
          capturing = 1'b0;
          mcnt  = 0;
          mline = 1'b0;
          mfer  = 1'b0;
        end
        d = ones ? 24'h000001 : {px[7:0], ln[7:0], 8'h5A};
        vga_vsync = vs_a ? SP : ~SP;
        vga_hsync = (px >= HA + HFP && px < HA + HFP + HSW) ? SP : ~SP;
        vga_valid = (px < len);
        {vga_r, vga_g, vga_b} = d;
        if (vga_valid && capturing && px < HA && ln < VA)
          wq.push_back('{cyc: cyc + 2, addr: {px[9:0], ln[8:0]}, data: d});
        if (capturing && ln == nvis + VFP && px == 0) begin
          fq.push_back(cyc + 2);
          if (nvis != VA) mfer = 1'b1;
          capturing = 1'b0;
        end
        if (rst) begin
          @(posedge clk);
          #1;
          check("rst_wr_en", {63'd0, wr_en}, 64'd0);
          check("rst_busy", {63'd0, busy}, 64'd0);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_wr_en", {63'd0, wr_en}, 64'd0);
    check("reset_wr_addr", {45'd0, wr_addr}, 64'd0);
    check("reset_wr_data", {40'd0, wr_data}, 64'd0);
    check("reset_frame_done", {63'd0, frame_done}, 64'd0);
    check("reset_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    check("reset_errs", {62'd0, line_err, frame_err}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    idle(4, 1'b0);

    // Frame A seen from HUNT (not captured), frame B captured cleanly.
    drive_frame(VA, -1, 1'b0, -1, -1, -1, 1'b0);
    drive_frame(VA, -1, 1'b1, -1, -1, -1, 1'b0);
    check("B_nwrites", 64'(nwr), 64'd48);
    check("B_last_addr", {45'd0, last_addr}, 64'h0E05);
    check("B_last_data", {40'd0, last_data}, 64'h07055A);
    check("B_frame_cnt", {48'd0, frame_cnt}, 64'd1);
    check("B_errs", {62'd0, line_err, frame_err}, 64'd0);

    // Frame C: line 2 one pixel short; then clear.
    drive_frame(VA, 2, 1'b1, -1, -1, -1, 1'b0);
    check("C_line_err", {63'd0, line_err}, 64'd1);
    idle(6, 1'b1);

    // Frame D: one surplus visible line.
    drive_frame(VA + 1, -1, 1'b1, -1, -1, -1, 1'b0);
    check("D_frame_err", {63'd0, frame_err}, 64'd1);
    check("D_nwrites", 64'(nwr), 64'd143);
    idle(6, 1'b1);

    // Frame E: declined at start, cap_en raised mid-frame; frame F captured.
    @(negedge clk);
    cap_en = 1'b0;
    drive_frame(VA, -1, 1'b0, -1, -1, 2, 1'b0);
    check("E_nwrites", 64'(nwr), 64'd143);
    check("E_frame_cnt", {48'd0, frame_cnt}, 64'd3);
    drive_frame(VA, -1, 1'b1, -1, -1, -1, 1'b0);
    check("F_frame_cnt", {48'd0, frame_cnt}, 64'd4);

    // Frame G: reset mid-frame; frame H captured with the count restarted.
    drive_frame(VA, -1, 1'b1, 3, 4, -1, 1'b0);
    check("G_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    drive_frame(VA, -1, 1'b1, -1, -1, -1, 1'b0);
    check("H_frame_cnt", {48'd0, frame_cnt}, 64'd1);

`ifdef VGA_CAPTURE_CHECKSUM_EN
    drive_frame(VA, -1, 1'b1, -1, -1, -1, 1'b1);
    check("I_checksum", {32'd0, checksum}, 64'd48);
`endif

    idle(4, 1'b0);
    check("scoreboard_drained", 64'(wq.size() + fq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
